puf_race_arbiter_bank: RTL

Parametrised, synchronous, multi-channel race arbiter for the parallel delay-PUF array. Each of N_CH channels receives the two finish lines of one delay-chain pair. Per challenge, the block:
- records which line of each pair arrived first,
- flags ties,
- enforces a timeout,
- presents the packed response word with a valid/ack handshake.

It sits between the delay-chain array and the response collector/UART framer.

---
 rtl/puf_arb_pkg.sv | 33 +++
 rtl/sync_2ff.sv | 26 ++
 rtl/puf_race_arbiter_bank.sv | 130 +++++++++++++
 3 files changed

// File: rtl/puf_arb_pkg.sv
// Shared definitions for the delay-PUF race arbiter bank.
// Contents:
//   state_t          - arbiter FSM states (IDLE, ARMED, DONE)
//   DEF_N_CH         - default number of arbiter channels
//   DEF_TIMEOUT      - default ARMED-cycle limit
//   DEF_CNT_W        - default timeout counter width
//   clog2()          - ceiling log2, used to check that the counter can reach TIMEOUT-1
package puf_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int unsigned DEF_N_CH    = 8;
   localparam int unsigned DEF_TIMEOUT = 200;
   localparam int unsigned DEF_CNT_W   = 8;

   // Bits needed to represent values 0 .. v-1 (returns 0 for v <= 1).
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned x;
      r = 0;
      x = 1;
      while (x < v) begin
         x = x << 1;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchroniser with synchronous, active-high reset.
// Ports:
//   clk   - destination clock
//   reset - synchronous reset, clears both flops
//   d     - asynchronous input
//   q     - synchronised output (two clk cycles of latency)
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/puf_race_arbiter_bank.sv
// Multi-channel race arbiter for the parallel delay-PUF array.
// Each channel watches the two finish lines of one delay-chain pair and records which one
// arrived first (or a tie), with a timeout, and hands the packed word over with valid/ack.
// Ports:
//   clk       - system clock
//   reset     - synchronous, active-high reset
//   start     - one-cycle pulse arming a new race (only honoured in IDLE)
//   fin_a     - per-channel finish line A (asynchronous)
//   fin_b     - per-channel finish line B (asynchronous)
//   ack       - collector has taken the response (honoured while valid)
//   busy      - high in ARMED and DONE
//   valid     - response/tie/decided/timed_out are stable
//   response  - 1 = A first; 0 = B first, tie or undecided
//   tie       - A and B seen in the same synchronised cycle
//   decided   - channel produced a result
//   timed_out - race ended by timeout with at least one channel undecided
module puf_race_arbiter_bank
   import puf_arb_pkg::*;
#(
   parameter int unsigned N_CH    = DEF_N_CH,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT,
   parameter int unsigned CNT_W   = DEF_CNT_W
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [N_CH-1:0] fin_a,
   input  logic [N_CH-1:0] fin_b,
   input  logic            ack,
   output logic            busy,
   output logic            valid,
   output logic [N_CH-1:0] response,
   output logic [N_CH-1:0] tie,
   output logic [N_CH-1:0] decided,
   output logic            timed_out
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   if (clog2(TIMEOUT) > CNT_W) begin : g_cnt_w_check
      $error("CNT_W too narrow for TIMEOUT");
   end

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [N_CH-1:0]  sa;
   logic [N_CH-1:0]  sb;
   logic [N_CH-1:0]  resp_nxt;
   logic [N_CH-1:0]  tie_nxt;
   logic [N_CH-1:0]  dec_nxt;

   for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
      sync_2ff u_sync_a (
         .clk   (clk),
         .reset (reset),
         .d     (fin_a[i]),
         .q     (sa[i])
      );

      sync_2ff u_sync_b (
         .clk   (clk),
         .reset (reset),
         .d     (fin_b[i]),
         .q     (sb[i])
      );

      // Once decided a channel is frozen; later edges on either line are ignored.
      assign dec_nxt[i]  = decided[i] | sa[i] | sb[i];
      assign resp_nxt[i] = decided[i] ? response[i] : (sa[i] & ~sb[i]);
      assign tie_nxt[i]  = decided[i] ? tie[i]      : (sa[i] & sb[i]);
   end

   // valid rises one cycle after entering DONE, so the last decision registered at edge D
   // is presented with valid after edge D+1.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         busy      <= 1'b0;
         valid     <= 1'b0;
         response  <= '0;
         tie       <= '0;
         decided   <= '0;
         timed_out <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state     <= ARMED;
                  busy      <= 1'b1;
                  cnt       <= '0;
                  response  <= '0;
                  tie       <= '0;
                  decided   <= '0;
                  timed_out <= 1'b0;
               end
            end
            ARMED: begin
               response <= resp_nxt;
               tie      <= tie_nxt;
               decided  <= dec_nxt;
               if (cnt != CNT_MAX) begin
                  cnt <= cnt + 1'b1;
               end
               // A decision completing on the timeout edge wins over the timeout.
               if (&dec_nxt) begin
                  state     <= DONE;
                  timed_out <= 1'b0;
               end else if (cnt == CNT_MAX) begin
                  state     <= DONE;
                  timed_out <= 1'b1;
               end
            end
            DONE: begin
               if (!valid) begin
                  valid <= 1'b1;
               end else if (ack) begin
                  valid <= 1'b0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
